// File: rtl/cp_insert_pkg.sv
// Shared constants and state encoding for the cyclic-prefix inserter.
// Optional last_out port is enabled by defining CP_INSERT_LAST_EN.
package cp_insert_pkg;

  localparam int SAMPLE_W   = 48;
  localparam int COMP_W     = 24;
  localparam int NFFT_DEF   = 128;
  localparam int CP_LEN_DEF = 9;

  typedef enum logic [1:0] {
    ST_FILL = 2'd0,
    ST_CP   = 2'd1,
    ST_BODY = 2'd2
  } cp_state_e;

endpackage

// File: rtl/cp_sym_ram.sv
// Symbol buffer: one write port, one synchronous read port whose output
// register holds when re_i is low and clears on reset.
module cp_sym_ram #(
  parameter int DEPTH = 128,
  parameter int W     = 48,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [W-1:0]  wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [W-1:0]  rdata_o
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) mem[waddr_i] <= wdata_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)   rdata_o <= '0;
    else if (re_i) rdata_o <= mem[raddr_i];
  end

endmodule

// File: rtl/cp_insert.sv
// Buffers one IFFT symbol, then replays its tail (cyclic prefix) followed by
// the full symbol. Define CP_INSERT_LAST_EN to add the last_out port.
//
// Handshake: a transfer happens on a rising edge where valid and ready are both
// high; once valid_out is high it, data_out and last_out stay stable until
// ready_in is seen high, and ready_out never depends on valid_in.
module cp_insert
  import cp_insert_pkg::*;
#(
  parameter int NFFT   = NFFT_DEF,
  parameter int CP_LEN = CP_LEN_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [SAMPLE_W-1:0] data_in,
  input  logic                valid_in,
  output logic                ready_out,
  output logic [SAMPLE_W-1:0] data_out,
  output logic                valid_out,
  input  logic                ready_in,
  output logic                ovf_out,
`ifdef CP_INSERT_LAST_EN
  output logic                last_out,
`endif
  output cp_state_e           state_dbg_o
);

  localparam int AW = $clog2(NFFT);
  localparam logic [AW-1:0] ONE       = AW'(1);
  localparam logic [AW-1:0] CP_BASE   = AW'(NFFT - CP_LEN);
  localparam logic [AW-1:0] CP_LAST   = AW'(CP_LEN - 1);
  localparam logic [AW-1:0] BODY_LAST = AW'(NFFT - 1);

  cp_state_e     state_q, state_d;
  logic [AW-1:0] wr_idx_q, wr_idx_d;
  logic [AW-1:0] rd_idx_q, rd_idx_d;
  logic          rd_done_q, rd_done_d;
  logic          valid_q, valid_d;
  logic          last_q, last_d;
  logic          ovf_q, ovf_d;
  logic          live_q;
  logic          adv, wr_en, rd_en;
  logic [AW-1:0] rd_addr;

  assign ready_out = live_q && (state_q == ST_FILL);
  assign wr_en     = valid_in && ready_out;
  // Output slot is free when empty or being consumed this cycle.
  assign adv       = !valid_q || ready_in;

  always_comb begin
    state_d   = state_q;
    wr_idx_d  = wr_idx_q;
    rd_idx_d  = rd_idx_q;
    rd_done_d = rd_done_q;
    valid_d   = valid_q;
    last_d    = last_q;
    rd_en     = 1'b0;
    rd_addr   = rd_idx_q;
    ovf_d     = ovf_q | (valid_in && !ready_out);
    if (adv) begin
      valid_d = 1'b0;
      last_d  = 1'b0;
    end
    case (state_q)
      ST_FILL: begin
        if (wr_en) begin
          wr_idx_d = wr_idx_q + ONE;
          if (wr_idx_q == BODY_LAST) begin
            state_d  = ST_CP;
            wr_idx_d = '0;
          end
        end
      end
      ST_CP: begin
        if (adv) begin
          rd_en   = 1'b1;
          rd_addr = CP_BASE + rd_idx_q;
          valid_d = 1'b1;
          if (rd_idx_q == CP_LAST) begin
            state_d  = ST_BODY;
            rd_idx_d = '0;
          end else begin
            rd_idx_d = rd_idx_q + ONE;
          end
        end
      end
      ST_BODY: begin
        if (adv && !rd_done_q) begin
          rd_en   = 1'b1;
          rd_addr = rd_idx_q;
          valid_d = 1'b1;
          if (rd_idx_q == BODY_LAST) begin
            rd_done_d = 1'b1;
            last_d    = 1'b1;
            rd_idx_d  = '0;
          end else begin
            rd_idx_d = rd_idx_q + ONE;
          end
        end
        // Buffer is released only once the final sample has left the block.
        if (valid_q && ready_in && last_q) begin
          state_d   = ST_FILL;
          rd_done_d = 1'b0;
        end
      end
      default: state_d = ST_FILL;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_FILL;
      wr_idx_q  <= '0;
      rd_idx_q  <= '0;
      rd_done_q <= 1'b0;
      valid_q   <= 1'b0;
      last_q    <= 1'b0;
      ovf_q     <= 1'b0;
      live_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_idx_q  <= wr_idx_d;
      rd_idx_q  <= rd_idx_d;
      rd_done_q <= rd_done_d;
      valid_q   <= valid_d;
      last_q    <= last_d;
      ovf_q     <= ovf_d;
      live_q    <= 1'b1;
    end
  end

  cp_sym_ram #(
    .DEPTH(NFFT),
    .W    (SAMPLE_W),
    .AW   (AW)
  ) u_ram (
    .clk_i  (clk),
    .rst_ni (rst),
    .we_i   (wr_en),
    .waddr_i(wr_idx_q),
    .wdata_i(data_in),
    .re_i   (rd_en),
    .raddr_i(rd_addr),
    .rdata_o(data_out)
  );

  assign valid_out   = valid_q;
  assign ovf_out     = ovf_q;
  assign state_dbg_o = state_q;
`ifdef CP_INSERT_LAST_EN
  assign last_out    = last_q;
`endif

endmodule

// File: tb/tb_cp_insert.sv
// Self-checking bench for cp_insert: scenario table plus hand-written
// back-to-back and mid-symbol-reset sequences. CP_INSERT_LAST_EN adds last_out checks.
module tb_cp_insert;
  import cp_insert_pkg::*;

  localparam int NFFT   = 128;
  localparam int CP_LEN = 9;
  localparam int W      = 48;
  localparam int XW     = W + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [W-1:0]  data_in = '0;
  logic          valid_in = 1'b0;
  logic          ready_in = 1'b1;
  logic          ready_out, valid_out, ovf_out;
  logic [W-1:0]  data_out;
  cp_state_e     state_dbg;
`ifdef CP_INSERT_LAST_EN
  logic          last_out;
`endif

  cp_insert #(.NFFT(NFFT), .CP_LEN(CP_LEN)) dut (
    .clk        (clk),
    .rst        (rst),
    .data_in    (data_in),
    .valid_in   (valid_in),
    .ready_out  (ready_out),
    .data_out   (data_out),
    .valid_out  (valid_out),
    .ready_in   (ready_in),
    .ovf_out    (ovf_out),
`ifdef CP_INSERT_LAST_EN
    .last_out   (last_out),
`endif
    .state_dbg_o(state_dbg)
  );

  // clock / watchdog
  initial forever #5 clk = ~clk;
  initial begin
    #1000000;
    $display("FAIL watchdog act=timeout req=finish");
    $fatal(1, "watchdog");
  end

  int errors = 0;
  int checks = 0;
  logic [XW-1:0] exp_q[$];
  int  stall_mode = 0;
  int  cyc = 0;
  int  xfers = 0;
  int  first_cyc = 0;
  int  last_cyc = 0;
  logic         prev_stall = 1'b0;
  logic [W-1:0] prev_data = '0;
  logic         prev_last = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s act=%0h req=%0h", name, act, req);
    end
  endtask

  function automatic logic [W-1:0] pack(input int v);
    logic signed [23:0] r;
    r = 24'(v);
    return {r, -r};
  endfunction

  // ready_in driver: constant 1, or 1,0,0,1 repeating
  initial begin
    int ph = 0;
    forever begin
      @(posedge clk); #1;
      if (stall_mode != 0) begin
        ready_in = (ph == 0) || (ph == 3);
        ph = (ph + 1) % 4;
      end else begin
        ready_in = 1'b1;
        ph = 0;
      end
    end
  end

  // scoreboard / hold monitor
  always @(negedge clk) begin
    logic [XW-1:0] e;
    if (!rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("hold_valid", 64'(valid_out), 64'(1'b1));
        chk("hold_data", 64'(data_out), 64'(prev_data));
`ifdef CP_INSERT_LAST_EN
        chk("hold_last", 64'(last_out), 64'(prev_last));
`endif
      end
      if (valid_out && ready_in) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output act=%0h req=none", data_out);
        end else begin
          e = exp_q.pop_front();
          chk("data", 64'(data_out), 64'(e[W-1:0]));
`ifdef CP_INSERT_LAST_EN
          chk("last", 64'(last_out), 64'(e[W]));
`endif
        end
        if (xfers == 0) first_cyc = cyc;
        last_cyc = cyc;
        xfers++;
      end
      prev_stall = valid_out && !ready_in;
      prev_data  = data_out;
`ifdef CP_INSERT_LAST_EN
      prev_last  = last_out;
`endif
    end
    cyc++;
  end

  task automatic do_reset();
    rst = 1'b0;
    valid_in = 1'b0;
    #1;
    chk("rst_valid", 64'(valid_out), 64'(1'b0));
    chk("rst_data", 64'(data_out), 64'(0));
    chk("rst_ovf", 64'(ovf_out), 64'(1'b0));
    chk("rst_state", 64'(state_dbg), 64'(ST_FILL));
    exp_q.delete();
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_ready", 64'(ready_out), 64'(1'b1));
  endtask

  task automatic send_symbol(input int base, input int count, input bit inject);
    for (int n = 0; n < count; n++) begin
      int b = 0;
      @(negedge clk);
      while (!ready_out && b < 300) begin
        @(negedge clk);
        b++;
      end
      if (!ready_out) begin
        chk("ready_timeout", 64'(ready_out), 64'(1'b1));
        return;
      end
      valid_in = 1'b1;
      data_in  = pack(base + n);
      @(posedge clk); #1;
      valid_in = 1'b0;
    end
    if (count == NFFT) begin
      for (int k = NFFT - CP_LEN; k < NFFT; k++) exp_q.push_back({1'b0, pack(base + k)});
      for (int k = 0; k < NFFT; k++) exp_q.push_back({1'(k == NFFT - 1), pack(base + k)});
      if (inject) begin
        valid_in = 1'b1;
        data_in  = 48'hAAAA;
      end
      @(negedge clk);
      chk("ready_drop", 64'(ready_out), 64'(1'b0));
      chk("valid_t1", 64'(valid_out), 64'(1'b0));
      @(posedge clk); #1;
      @(negedge clk);
      chk("valid_t2", 64'(valid_out), 64'(1'b1));
      @(posedge clk); #1;
      valid_in = 1'b0;
    end
  endtask

  task automatic drain();
    int b = 0;
    while (exp_q.size() != 0 && b < 3000) begin
      @(posedge clk);
      b++;
    end
    if (exp_q.size() != 0) begin
      chk("drain_timeout", 64'(exp_q.size()), 64'(0));
      exp_q.delete();
    end
    repeat (3) @(negedge clk);
    chk("idle_valid", 64'(valid_out), 64'(1'b0));
  endtask

  typedef struct {
    int base;
    int stall;
    bit inject;
    int exp_xfers;
    bit exp_ovf;
  } scen_t;

  scen_t tbl[4];

  initial begin
    tbl[0] = '{base: 0,    stall: 0, inject: 1'b0, exp_xfers: 137, exp_ovf: 1'b0};
    tbl[1] = '{base: 0,    stall: 1, inject: 1'b0, exp_xfers: 137, exp_ovf: 1'b0};
    tbl[2] = '{base: 0,    stall: 0, inject: 1'b1, exp_xfers: 137, exp_ovf: 1'b1};
    tbl[3] = '{base: int'($urandom_range(1, 5000)), stall: 1, inject: 1'b1,
               exp_xfers: 137, exp_ovf: 1'b1};

    for (int i = 0; i < 4; i++) begin
      do_reset();
      stall_mode = tbl[i].stall;
      xfers = 0;
      send_symbol(tbl[i].base, NFFT, tbl[i].inject);
      drain();
      chk("xfer_count", 64'(xfers), 64'(tbl[i].exp_xfers));
      if (tbl[i].stall == 0) chk("no_gaps", 64'(last_cyc - first_cyc), 64'(tbl[i].exp_xfers - 1));
      chk("ovf", 64'(ovf_out), 64'(tbl[i].exp_ovf));
    end

    // back-to-back symbols
    do_reset();
    stall_mode = 0;
    xfers = 0;
    send_symbol(0, NFFT, 1'b0);
    send_symbol(1000, NFFT, 1'b0);
    drain();
    chk("b2b_xfers", 64'(xfers), 64'(2 * (NFFT + CP_LEN)));
    chk("b2b_ovf", 64'(ovf_out), 64'(1'b0));

    // reset in the middle of a fill
    do_reset();
    send_symbol(0, 60, 1'b0);
    do_reset();
    xfers = 0;
    send_symbol(500, NFFT, 1'b0);
    drain();
    chk("midrst_xfers", 64'(xfers), 64'(NFFT + CP_LEN));
    chk("midrst_ovf", 64'(ovf_out), 64'(1'b0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cp_insert.md
CP_INSERT -- requirements
Module: cp_insert

Interface
REQ-001 Parameter NFFT, default 128, symbol length in samples (power of two).
REQ-002 Parameter CP_LEN, default 9, cyclic-prefix length in samples, range 1..NFFT-1.
REQ-003 clk  input  1  single clock; all state is updated on the rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 data_in  input  48  signed complex sample from the IFFT: [47:24] real, [23:0] imaginary.
REQ-006 valid_in  input  1  data_in is valid this cycle.
REQ-007 ready_out  output  1  block accepts data_in this cycle.
REQ-008 data_out  output  48  signed complex output sample, same packing as data_in.
REQ-009 valid_out  output  1  data_out is valid.
REQ-010 ready_in  input  1  downstream accepts data_out this cycle.
REQ-011 ovf_out  output  1  sticky flag: an input sample was dropped.

Function
REQ-012 The block SHALL have three states: FILL, CP and BODY.
REQ-013 In FILL, ready_out SHALL be 1, and each valid_in cycle SHALL write data_in to buffer[wr_idx] and increment wr_idx.
REQ-014 When the NFFT-th sample is accepted, the block SHALL go to CP and clear wr_idx.
REQ-015 In CP and BODY, ready_out SHALL be 0.
REQ-016 The block uses a single buffer with no overlap of fill and drain.
REQ-017 In CP, output k (k = 0..CP_LEN-1) SHALL carry buffer[NFFT-CP_LEN+k].
REQ-018 In BODY, output k (k = 0..NFFT-1) SHALL carry buffer[k].
REQ-019 Each symbol SHALL therefore produce exactly NFFT+CP_LEN output transfers.
REQ-020 The first valid_out SHALL assert in the 2nd cycle after the cycle that accepted the last input sample (one-cycle synchronous RAM read).
REQ-021 A transfer occurs when valid_out=1 and ready_in=1.
REQ-022 While valid_out=1 and ready_in=0, data_out and valid_out SHALL hold stable, and the read index SHALL NOT advance.
REQ-023 While ready_in stays 1, the block SHALL deliver one transfer per cycle with no bubbles between CP and BODY.
REQ-024 After the final BODY transfer, the block SHALL return to FILL, with ready_out=1 in the next cycle; valid_out SHALL deassert unless stalled.
REQ-025 A valid_in cycle with ready_out=0 SHALL drop the sample and set ovf_out=1.
REQ-026 ovf_out SHALL be cleared only by reset.
REQ-027 Samples SHALL pass bit-exact: no scaling, rounding or sign change.

Reset
REQ-028 On rst=0, the block SHALL asynchronously enter FILL with wr_idx=0, read index=0, valid_out=0, ovf_out=0 and data_out=0.
REQ-029 ready_out SHALL be 1 from the first clock edge after rst is released.
REQ-030 Reset mid-symbol SHALL abandon the partial symbol; buffer contents need not be cleared.

Configuration
REQ-031 With macro CP_INSERT_LAST_EN defined, the block SHALL add output port last_out (1 bit), asserted with the final BODY sample and obeying the same hold rule as data_out, with reset value 0.
REQ-032 Without CP_INSERT_LAST_EN, last_out SHALL NOT exist and all other behaviour SHALL be identical.

Structure
REQ-033 The shared package SHALL hold the sample width constant (48), the component width (24), the default NFFT/CP_LEN values and the state enumeration type.
REQ-034 The buffer SHALL be a separate sub-module, cp_sym_ram: NFFT x 48, one write port, one synchronous-read port.

Verification
REQ-035 Reset-state check: after reset, feed samples with real=n, imag=-n (n = 0..127) and hold ready_in=1. Required: ready_out drops after n=127; valid_out rises 2 cycles later; the output is real 119..127 then 0..127; exactly 137 transfers occur with no gaps.
REQ-036 Backpressure: toggle ready_in 1,0,0,1 repeatedly during drain. Required: data_out is stable across every stalled cycle, and the output sequence is identical to REQ-035.
REQ-037 Overflow: assert valid_in with data 0xAAAA during the CP state. Required: ovf_out=1 and stays set, and the output sequence is unchanged.
REQ-038 Back-to-back symbols: present a second symbol (n+1000) the cycle ready_out returns to 1. Required: the second output block begins with real 1119, and no sample is lost.
REQ-039 Mid-symbol reset: assert rst=0 after 60 input samples, then send a full symbol. Required: the output contains only the new symbol, and ovf_out=0.
REQ-040 With CP_INSERT_LAST_EN defined: last_out=1 only on the 137th transfer (real=127), and it is held while ready_in=0.
